touch_referee: RTL and testbench

Rally referee for the volleyball game. Watches player-ball collision inputs and the ground-collision output of the ball position controller. Counts consecutive touches per side, asserts `ovr_touch` back to the ball controller when a side exceeds its touch limit, and awards points and the serve. Runs on the 65 MHz pixel clock alongside the ball controller. Its score outputs feed the score display.

---
 rtl/touch_referee.sv | 157 +++++++++++++++
 tb/tb_touch_referee.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/touch_referee.sv
// rtl/touch_referee.sv - rally referee: touch counting, over-touch fault, scoring and serve.
// Optional TOUCH_REFEREE_DEUCE_EN: win requires a 2-point lead (or reaching 31).
module touch_referee #(
  parameter int MAX_TOUCHES  = 3,
  parameter int NET_X        = 512,
  parameter int BALL_SIZE    = 64,
  parameter int GHOST_CYCLES = 16_250_000,
  parameter int OVR_HOLD     = 1_300_000,
  parameter int WIN_SCORE    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic        gnd_col,
  input  logic [11:0] ball_posx,
  input  logic        new_game,
  output logic        ovr_touch,
  output logic        point_pl1,
  output logic        point_pl2,
  output logic [4:0]  score_pl1,
  output logic [4:0]  score_pl2,
  output logic        serve_side,
  output logic        game_over
);

  localparam int GW = $clog2(GHOST_CYCLES + 1);
  localparam int OW = $clog2(OVR_HOLD + 1);
  localparam int CW = $clog2(MAX_TOUCHES + 2);

  typedef enum logic [2:0] {SERVE, RALLY, FAULT, SETTLE, GAME_OVER} state_e;

  state_e          state_q, state_d;
  logic            pl1_s_q, pl1_p_q, pl2_s_q, pl2_p_q, gnd_s_q, gnd_p_q;
  logic [11:0]     posx_q;
  logic [CW-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d, n1, n2;
  logic [GW-1:0]   ghost_q, ghost_d;
  logic            ghost_pl_q, ghost_pl_d;
  logic [OW-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic            ovr_q, ovr_d, pt1_q, pt1_d, pt2_q, pt2_d;
  logic [4:0]      score1_q, score1_d, score2_q, score2_d;
  logic            serve_q, serve_d, over_q, over_d;
  logic            pl1_ev, pl2_ev, gnd_ev, side, tk1, tk2, award1, award2, won;
  logic [12:0]     center;
  logic [5:0]      s1w, s2w;

  assign pl1_ev = pl1_s_q & ~pl1_p_q;
  assign pl2_ev = pl2_s_q & ~pl2_p_q;
  assign gnd_ev = gnd_s_q & ~gnd_p_q;
  assign center = {1'b0, posx_q} + 13'(BALL_SIZE / 2);
  assign side   = (center >= 13'(NET_X));

  // Simultaneous player edges: only the player on the ball's side counts; then the ghost filter applies.
  assign tk1 = pl1_ev && (!pl2_ev || !side) && !((ghost_q > GW'(1)) && !ghost_pl_q);
  assign tk2 = pl2_ev && (!pl1_ev || side) && !((ghost_q > GW'(1)) && ghost_pl_q);

  assign s1w = {1'b0, score1_q};
  assign s2w = {1'b0, score2_q};
`ifdef TOUCH_REFEREE_DEUCE_EN
  assign won = (s1w >= 6'(WIN_SCORE) && s1w >= s2w + 6'd2) ||
               (s2w >= 6'(WIN_SCORE) && s2w >= s1w + 6'd2) ||
               (score1_q == 5'd31) || (score2_q == 5'd31);
`else
  assign won = (s1w >= 6'(WIN_SCORE)) || (s2w >= 6'(WIN_SCORE));
`endif

  always_comb begin
    state_d    = state_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    ghost_d    = (ghost_q != '0) ? ghost_q - GW'(1) : '0;
    ghost_pl_d = ghost_pl_q;
    ovr_d      = ovr_q;
    ovr_cnt_d  = ovr_cnt_q;
    award1     = 1'b0;
    award2     = 1'b0;
    n1         = cnt1_q + CW'(1);
    n2         = cnt2_q + CW'(1);
    case (state_q)
      SERVE, RALLY: begin
        if (state_q == RALLY && gnd_ev) begin
          state_d = SETTLE;
          if (side) award1 = 1'b1;
          else      award2 = 1'b1;
        end else if (tk1) begin
          state_d = RALLY; cnt1_d = n1; cnt2_d = '0;
          ghost_d = GW'(GHOST_CYCLES); ghost_pl_d = 1'b0;
          if (n1 == CW'(MAX_TOUCHES + 1)) begin
            state_d = FAULT; award2 = 1'b1; ovr_d = 1'b1; ovr_cnt_d = OW'(OVR_HOLD - 1);
          end
        end else if (tk2) begin
          state_d = RALLY; cnt2_d = n2; cnt1_d = '0;
          ghost_d = GW'(GHOST_CYCLES); ghost_pl_d = 1'b1;
          if (n2 == CW'(MAX_TOUCHES + 1)) begin
            state_d = FAULT; award1 = 1'b1; ovr_d = 1'b1; ovr_cnt_d = OW'(OVR_HOLD - 1);
          end
        end
      end
      FAULT: begin
        cnt1_d = '0; cnt2_d = '0; ghost_d = '0;
        if (ovr_cnt_q == '0) begin
          ovr_d = 1'b0; state_d = SETTLE;
        end else begin
          ovr_cnt_d = ovr_cnt_q - OW'(1);
        end
      end
      SETTLE: begin
        cnt1_d = '0; cnt2_d = '0; ghost_d = '0;
        if (!gnd_s_q && !pl1_s_q && !pl2_s_q) state_d = won ? GAME_OVER : SERVE;
      end
      GAME_OVER: begin
        cnt1_d = '0; cnt2_d = '0; ghost_d = '0;
      end
      default: state_d = SERVE;
    endcase

    pt1_d    = award1;
    pt2_d    = award2;
    score1_d = (award1 && score1_q != 5'd31) ? score1_q + 5'd1 : score1_q;
    score2_d = (award2 && score2_q != 5'd31) ? score2_q + 5'd1 : score2_q;
    serve_d  = award1 ? 1'b0 : (award2 ? 1'b1 : serve_q);

    if (new_game) begin
      state_d = SERVE; cnt1_d = '0; cnt2_d = '0; ghost_d = '0; ovr_d = 1'b0; ovr_cnt_d = '0;
      pt1_d = 1'b0; pt2_d = 1'b0; score1_d = '0; score2_d = '0; serve_d = 1'b0;
    end
    over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SERVE;
      {pl1_s_q, pl1_p_q, pl2_s_q, pl2_p_q, gnd_s_q, gnd_p_q} <= 6'b111111;
      posx_q <= '0; cnt1_q <= '0; cnt2_q <= '0; ghost_q <= '0; ghost_pl_q <= 1'b0;
      ovr_cnt_q <= '0; ovr_q <= 1'b0; pt1_q <= 1'b0; pt2_q <= 1'b0;
      score1_q <= '0; score2_q <= '0; serve_q <= 1'b0; over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pl1_s_q <= pl1_col; pl1_p_q <= pl1_s_q;
      pl2_s_q <= pl2_col; pl2_p_q <= pl2_s_q;
      gnd_s_q <= gnd_col; gnd_p_q <= gnd_s_q;
      posx_q <= ball_posx; cnt1_q <= cnt1_d; cnt2_q <= cnt2_d;
      ghost_q <= ghost_d; ghost_pl_q <= ghost_pl_d;
      ovr_cnt_q <= ovr_cnt_d; ovr_q <= ovr_d; pt1_q <= pt1_d; pt2_q <= pt2_d;
      score1_q <= score1_d; score2_q <= score2_d; serve_q <= serve_d; over_q <= over_d;
    end
  end

  assign ovr_touch  = ovr_q;
  assign point_pl1  = pt1_q;
  assign point_pl2  = pt2_q;
  assign score_pl1  = score1_q;
  assign score_pl2  = score2_q;
  assign serve_side = serve_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_touch_referee.sv
// tb/tb_touch_referee.sv - directed self-checking bench for touch_referee.
module tb_touch_referee;
  logic        clk = 1'b0;
  logic        rst, pl1_col, pl2_col, gnd_col, new_game;
  logic [11:0] ball_posx;
  logic        ovr_touch, point_pl1, point_pl2, serve_side, game_over;
  logic [4:0]  score_pl1, score_pl2;
  int checks = 0, failures = 0;
  int p1_pulses = 0, p2_pulses = 0, ovr_cycles = 0;

  always #5 clk = ~clk;

  touch_referee #(.GHOST_CYCLES(8), .OVR_HOLD(4), .WIN_SCORE(3)) dut (
    .clk(clk), .rst(rst), .pl1_col(pl1_col), .pl2_col(pl2_col), .gnd_col(gnd_col),
    .ball_posx(ball_posx), .new_game(new_game), .ovr_touch(ovr_touch),
    .point_pl1(point_pl1), .point_pl2(point_pl2), .score_pl1(score_pl1),
    .score_pl2(score_pl2), .serve_side(serve_side), .game_over(game_over)
  );

  always @(negedge clk) begin
    if (point_pl1) p1_pulses++;
    if (point_pl2) p2_pulses++;
    if (ovr_touch) ovr_cycles++;
  end

  task tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task pulse(input int which);
    if (which == 0) pl1_col = 1'b1; else if (which == 1) pl2_col = 1'b1; else gnd_col = 1'b1;
    tick(1);
    if (which == 0) pl1_col = 1'b0; else if (which == 1) pl2_col = 1'b0; else gnd_col = 1'b0;
    tick(1);
  endtask

  task ground_point(input logic [11:0] x);
    ball_posx = x;
    pulse(0); tick(3);
    gnd_col = 1'b1; tick(3);
    gnd_col = 1'b0; tick(4);
  endtask

  task test_reset;
    rst = 1'b0; pl1_col = 1'b1; pl2_col = 1'b0; gnd_col = 1'b0; new_game = 1'b0; ball_posx = 12'd200;
    tick(3);
    checks++; if (ovr_touch !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %0d expected 0", ovr_touch); end
    checks++; if (point_pl1 !== 1'b0 || point_pl2 !== 1'b0) begin failures++; $display("FAIL reset_point: got %0d/%0d expected 0/0", point_pl1, point_pl2); end
    checks++; if (score_pl1 !== 5'd0 || score_pl2 !== 5'd0) begin failures++; $display("FAIL reset_score: got %0d/%0d expected 0/0", score_pl1, score_pl2); end
    checks++; if (serve_side !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_serve_over: got %0d/%0d expected 0/0", serve_side, game_over); end
    rst = 1'b1; tick(3);
    pl1_col = 1'b0; tick(2);
    pulse(2); tick(4);
    checks++; if (p1_pulses + p2_pulses !== 0) begin failures++; $display("FAIL reset_no_touch: got %0d points expected 0", p1_pulses + p2_pulses); end
  endtask

  task test_over_touch;
    int b_ovr, b_p1, b_p2;
    b_ovr = ovr_cycles; b_p1 = p1_pulses; b_p2 = p2_pulses; ball_posx = 12'd200;
    for (int i = 0; i < 3; i++) begin pulse(0); tick(8); end
    checks++; if (ovr_cycles !== b_ovr) begin failures++; $display("FAIL over_early: got %0d ovr cycles expected 0", ovr_cycles - b_ovr); end
    pulse(0); tick(12);
    checks++; if (ovr_cycles - b_ovr !== 4) begin failures++; $display("FAIL over_len: got %0d expected 4", ovr_cycles - b_ovr); end
    checks++; if (p2_pulses - b_p2 !== 1 || p1_pulses !== b_p1) begin failures++; $display("FAIL over_pulse: got p2=%0d p1=%0d expected 1 0", p2_pulses - b_p2, p1_pulses - b_p1); end
    checks++; if (score_pl2 !== 5'd1 || score_pl1 !== 5'd0) begin failures++; $display("FAIL over_score: got %0d-%0d expected 0-1", score_pl1, score_pl2); end
    checks++; if (serve_side !== 1'b1) begin failures++; $display("FAIL over_serve: got %0d expected 1", serve_side); end
  endtask

  task test_ghost;
    int b_ovr, b_p2;
    b_ovr = ovr_cycles; b_p2 = p2_pulses; ball_posx = 12'd200;
    for (int i = 0; i < 4; i++) pulse(0);
    tick(10);
    checks++; if (ovr_cycles !== b_ovr) begin failures++; $display("FAIL ghost_burst: got %0d ovr cycles expected 0", ovr_cycles - b_ovr); end
    pulse(0); tick(8); pulse(0); tick(8);
    checks++; if (ovr_cycles !== b_ovr) begin failures++; $display("FAIL ghost_count3: got %0d ovr cycles expected 0", ovr_cycles - b_ovr); end
    pulse(0); tick(12);
    checks++; if (ovr_cycles - b_ovr !== 4 || p2_pulses - b_p2 !== 1) begin failures++; $display("FAIL ghost_count4: got ovr=%0d p2=%0d expected 4 1", ovr_cycles - b_ovr, p2_pulses - b_p2); end
    checks++; if (score_pl2 !== 5'd2) begin failures++; $display("FAIL ghost_score: got %0d expected 2", score_pl2); end
  endtask

  task test_ground_point;
    int b_p1, b_p2;
    b_p1 = p1_pulses; b_p2 = p2_pulses; ball_posx = 12'd700;
    pulse(0); tick(3);
    gnd_col = 1'b1; tick(3);
    checks++; if (p1_pulses - b_p1 !== 1 || score_pl1 !== 5'd1) begin failures++; $display("FAIL ground_point: got p1=%0d score=%0d expected 1 1", p1_pulses - b_p1, score_pl1); end
    checks++; if (serve_side !== 1'b0) begin failures++; $display("FAIL ground_serve: got %0d expected 0", serve_side); end
    pl2_col = 1'b1; tick(2);
    gnd_col = 1'b0; tick(2);
    gnd_col = 1'b1; tick(3);
    checks++; if (p1_pulses - b_p1 !== 1 || p2_pulses !== b_p2 || score_pl1 !== 5'd1) begin failures++; $display("FAIL ground_second: got p1=%0d p2=%0d score=%0d expected 1 0 1", p1_pulses - b_p1, p2_pulses - b_p2, score_pl1); end
    gnd_col = 1'b0; pl2_col = 1'b0; tick(4);
  endtask

  task test_simultaneous;
    int b_p1, b_p2;
    b_p1 = p1_pulses; b_p2 = p2_pulses; ball_posx = 12'd700;
    pulse(0); tick(3);
    gnd_col = 1'b1; pl2_col = 1'b1; tick(3);
    checks++; if (p1_pulses - b_p1 !== 1 || p2_pulses !== b_p2) begin failures++; $display("FAIL simul_pulse: got p1=%0d p2=%0d expected 1 0", p1_pulses - b_p1, p2_pulses - b_p2); end
    checks++; if (score_pl1 !== 5'd2 || score_pl2 !== 5'd2) begin failures++; $display("FAIL simul_score: got %0d-%0d expected 2-2", score_pl1, score_pl2); end
    gnd_col = 1'b0; pl2_col = 1'b0; tick(4);
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL simul_not_over: got %0d expected 0", game_over); end
  endtask

  task test_game_over;
    int b_ovr, b_p1, b_p2;
    ground_point(12'd200);
    checks++; if (score_pl2 !== 5'd3) begin failures++; $display("FAIL over_third: got %0d expected 3", score_pl2); end
`ifdef TOUCH_REFEREE_DEUCE_EN
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL over_deuce_flag: got %0d expected 0", game_over); end
`else
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_flag: got %0d expected 1", game_over); end
    b_ovr = ovr_cycles; b_p1 = p1_pulses; b_p2 = p2_pulses;
    for (int i = 0; i < 4; i++) begin pulse(0); tick(8); end
    pulse(2); tick(4);
    checks++; if (ovr_cycles !== b_ovr || p1_pulses !== b_p1 || p2_pulses !== b_p2) begin failures++; $display("FAIL over_ignored: got ovr=%0d p1=%0d p2=%0d expected 0 0 0", ovr_cycles - b_ovr, p1_pulses - b_p1, p2_pulses - b_p2); end
    checks++; if (score_pl1 !== 5'd2 || score_pl2 !== 5'd3 || game_over !== 1'b1) begin failures++; $display("FAIL over_hold: got %0d-%0d over=%0d expected 2-3 over=1", score_pl1, score_pl2, game_over); end
`endif
    new_game = 1'b1; tick(1); new_game = 1'b0; tick(1);
    checks++; if (score_pl1 !== 5'd0 || score_pl2 !== 5'd0) begin failures++; $display("FAIL new_game_score: got %0d-%0d expected 0-0", score_pl1, score_pl2); end
    checks++; if (game_over !== 1'b0 || serve_side !== 1'b0) begin failures++; $display("FAIL new_game_flags: got over=%0d serve=%0d expected 0 0", game_over, serve_side); end
  endtask

`ifdef TOUCH_REFEREE_DEUCE_EN
  task test_deuce;
    for (int i = 0; i < 3; i++) begin ground_point(12'd700); ground_point(12'd200); end
    checks++; if (score_pl1 !== 5'd3 || score_pl2 !== 5'd3 || game_over !== 1'b0) begin failures++; $display("FAIL deuce_33: got %0d-%0d over=%0d expected 3-3 over=0", score_pl1, score_pl2, game_over); end
    ground_point(12'd700);
    checks++; if (score_pl1 !== 5'd4 || game_over !== 1'b0) begin failures++; $display("FAIL deuce_43: got %0d over=%0d expected 4 over=0", score_pl1, game_over); end
    ground_point(12'd700);
    checks++; if (score_pl1 !== 5'd5 || game_over !== 1'b1) begin failures++; $display("FAIL deuce_53: got %0d over=%0d expected 5 over=1", score_pl1, game_over); end
    new_game = 1'b1; tick(1); new_game = 1'b0; tick(1);
  endtask
`endif

  task test_reset_mid_play;
    int b_p1, b_p2;
    ball_posx = 12'd200;
    pulse(0);
    rst = 1'b0; tick(1); rst = 1'b1; tick(2);
    b_p1 = p1_pulses; b_p2 = p2_pulses;
    pulse(2); tick(4);
    checks++; if (p1_pulses !== b_p1 || p2_pulses !== b_p2) begin failures++; $display("FAIL rst_rally: got p1=%0d p2=%0d expected 0 0", p1_pulses - b_p1, p2_pulses - b_p2); end
    for (int i = 0; i < 3; i++) begin pulse(0); tick(8); end
    pulse(0);
    checks++; if (ovr_touch !== 1'b1 || score_pl2 !== 5'd1) begin failures++; $display("FAIL rst_fault_enter: got ovr=%0d score=%0d expected 1 1", ovr_touch, score_pl2); end
    rst = 1'b0; tick(1);
    checks++; if (ovr_touch !== 1'b0 || score_pl2 !== 5'd0) begin failures++; $display("FAIL rst_fault: got ovr=%0d score=%0d expected 0 0", ovr_touch, score_pl2); end
    rst = 1'b1; tick(2);
  endtask

  initial begin
    test_reset();
    test_over_touch();
    test_ghost();
    test_ground_point();
    test_simultaneous();
    test_game_over();
`ifdef TOUCH_REFEREE_DEUCE_EN
    test_deuce();
`endif
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
